// File: rtl/pulse_gen_pkg.sv
// Shared encodings and edge-qualification helper for the multi-channel one-shot pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  function automatic logic edge_qualify(input mode_e m, input logic rise, input logic fall);
    logic hit;
    case (m)
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pulse_gen_multi_channel.sv
// One channel: optional synchroniser, edge detect, IDLE/PULSE/HOLD sequencer and sticky drop flag.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] pulse_len_i,
  input  logic [CNT_W-1:0] holdoff_i,
  input  logic             clear_dropped_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             dropped_o
);

  logic s;
  logic s_d_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = sig_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= (sync_q << 1) | SYNC_STAGES'(sig_i);
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  logic rise, fall, edge_hit;
  assign rise     = s & ~s_d_q;
  assign fall     = ~s & s_d_q;
  assign edge_hit = edge_qualify(mode_e'(mode_i), rise, fall);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pulse_q, pulse_d;
  logic             dropped_q, dropped_d;
  logic             drop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pulse_d = pulse_q;
    drop    = 1'b0;
    // Mode off overrides whatever the sequencer is doing, truncating a live pulse.
    if (mode_e'(mode_i) == MODE_OFF) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_hit) begin
            state_d = ST_PULSE;
            cnt_d   = (pulse_len_i == '0) ? '0 : pulse_len_i - CNT_W'(1);
            hold_d  = holdoff_i;
            pulse_d = 1'b1;
          end
        end
        ST_PULSE: begin
          drop = edge_hit;
          if (cnt_q == '0) begin
            pulse_d = 1'b0;
            if (hold_q != '0) begin
              state_d = ST_HOLD;
              cnt_d   = hold_q - CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          drop = edge_hit;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pulse_d = 1'b0;
        end
      endcase
    end
    dropped_d = drop ? 1'b1 : (clear_dropped_i ? 1'b0 : dropped_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      pulse_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      s_d_q     <= s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      pulse_q   <= pulse_d;
      dropped_q <= dropped_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign dropped_o = dropped_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Top level: one independent pulse_gen_channel per input, sharing pulse length and hold-off.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sig_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CNT_W-1:0]      pulse_len,
  input  logic [CNT_W-1:0]      holdoff,
  input  logic [CHANNELS-1:0]   clear_dropped,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   dropped
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_gen_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .sig_i           (sig_in[i]),
      .mode_i          (mode[2*i +: 2]),
      .pulse_len_i     (pulse_len),
      .holdoff_i       (holdoff),
      .clear_dropped_i (clear_dropped[i]),
      .pulse_o         (pulse[i]),
      .busy_o          (busy[i]),
      .dropped_o       (dropped[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a per-channel countdown model.
module tb_pulse_gen_multi;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int SY = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   sig_in;
  logic [2*CH-1:0] mode;
  logic [CW-1:0]   pulse_len;
  logic [CW-1:0]   holdoff;
  logic [CH-1:0]   clear_dropped;
  logic [CH-1:0]   pulse, busy, dropped;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  pulse_gen_multi #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (SY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sig_in        (sig_in),
    .mode          (mode),
    .pulse_len     (pulse_len),
    .holdoff       (holdoff),
    .clear_dropped (clear_dropped),
    .pulse         (pulse),
    .busy          (busy),
    .dropped       (dropped)
  );

  always #5 clk = ~clk;

  // Model: remaining pulse cycles and remaining busy cycles per channel.
  int unsigned   prem [CH];
  int unsigned   rem  [CH];
  logic [CH-1:0] m_pulse = '0, m_busy = '0, m_drop = '0, prev_s = '0;
  logic [CH-1:0] hist [$];

  always @(posedge clk or negedge reset) begin : model
    logic [CH-1:0] s;
    logic [1:0]    m;
    logic          r, f, e, drp;
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin prem[c] = 0; rem[c] = 0; end
      m_pulse = '0; m_busy = '0; m_drop = '0; prev_s = '0;
      hist.delete();
    end else begin
      if (SY == 0) s = sig_in;
      else         s = (hist.size() >= SY) ? hist[hist.size() - SY] : '0;
      for (int c = 0; c < CH; c++) begin
        m   = mode[2*c +: 2];
        r   = s[c] & ~prev_s[c];
        f   = ~s[c] & prev_s[c];
        e   = (m == 2'd1 && r) || (m == 2'd2 && f) || (m == 2'd3 && (r || f));
        drp = 1'b0;
        if (m == 2'd0) begin
          prem[c] = 0; rem[c] = 0;
        end else if (rem[c] > 0) begin
          drp = e;
          rem[c]--;
          if (prem[c] > 0) prem[c]--;
        end else if (e) begin
          prem[c] = (pulse_len == 0) ? 1 : int'(pulse_len);
          rem[c]  = prem[c] + int'(holdoff);
        end
        m_drop[c]  = drp ? 1'b1 : (clear_dropped[c] ? 1'b0 : m_drop[c]);
        m_pulse[c] = prem[c] > 0;
        m_busy[c]  = rem[c] > 0;
      end
      prev_s = s;
      hist.push_back(sig_in);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      tests++;
      if (pulse !== m_pulse || busy !== m_busy || dropped !== m_drop) begin
        failed++;
        $display("FAIL cycle_check t=%0t pulse got %b want %b, busy got %b want %b, dropped got %b want %b",
                 $time, pulse, m_pulse, busy, m_busy, dropped, m_drop);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(input int ch, input int n, output int first, output int pw, output int bw);
    first = -1; pw = 0; bw = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pulse[ch]) begin
        if (first < 0) first = i;
        pw++;
      end
      if (busy[ch]) bw++;
    end
  endtask

  initial begin
    int first, pw, bw, cnt;
    reset = 1'b1; sig_in = 4'b0001; mode = 8'b00_00_00_01;
    pulse_len = 8'd1; holdoff = 8'd0; clear_dropped = '0;
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Input already high at reset release counts as a rising edge.
    cyc(2); #1 reset = 1'b1;
    measure(0, 8, first, pw, bw);
    check("release_latency", first, 3);
    check("release_width", pw, 1);
    check("release_busy", bw, 1);

    mode[3:2] = 2'b11; pulse_len = 8'd3; holdoff = 8'd2;
    for (int k = 0; k < 3; k++) begin
      sig_in[1] = ~sig_in[1];
      measure(1, 10, first, pw, bw);
      check("both_width", pw, 3);
      check("both_busy", bw, 5);
      check("both_dropped", int'(dropped[1]), 0);
    end

    mode[5:4] = 2'b01; pulse_len = 8'd4; holdoff = 8'd4;
    sig_in[2] = 1'b1; cyc(2); sig_in[2] = 1'b0; cyc(3); sig_in[2] = 1'b1; cyc(14);
    check("drop_set", int'(dropped[2]), 1);
    clear_dropped[2] = 1'b1; cyc(1); clear_dropped[2] = 1'b0;
    check("drop_clear", int'(dropped[2]), 0);
    sig_in[2] = 1'b0; cyc(2); sig_in[2] = 1'b1; cyc(1);
    sig_in[2] = 1'b0; cyc(1); sig_in[2] = 1'b1; cyc(2);
    clear_dropped[2] = 1'b1; cyc(1); clear_dropped[2] = 1'b0;
    check("drop_set_wins", int'(dropped[2]), 1);
    cyc(12);

    pulse_len = 8'd0; holdoff = 8'd0;
    sig_in[0] = 1'b0; cyc(3); sig_in[0] = 1'b1;
    measure(0, 6, first, pw, bw);
    check("len0_width", pw, 1);

    pulse_len = 8'd5;
    sig_in[0] = 1'b0; cyc(3); sig_in[0] = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (pulse[0]) cnt++;
      if (i == 4) pulse_len = 8'd2;
    end
    check("len_latched", cnt, 5);
    sig_in[0] = 1'b0; cyc(3); sig_in[0] = 1'b1;
    measure(0, 8, first, pw, bw);
    check("len_next", pw, 2);

    pulse_len = 8'd6; holdoff = 8'd0; mode[7:6] = 2'b01;
    sig_in[3] = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pulse[3]) cnt++;
      if (i == 4) mode[7:6] = 2'b00;
    end
    check("off_truncate", cnt, 2);
    check("off_busy", int'(busy[3]), 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      sig_in[3] = ~sig_in[3];
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (pulse[3]) cnt++; end
    end
    check("off_ignored", cnt, 0);
    sig_in[3] = 1'b0; cyc(4); mode[7:6] = 2'b01; cyc(3); sig_in[3] = 1'b1;
    measure(3, 10, first, pw, bw);
    check("off_restored", pw, 6);

    cyc(5);
    mode = 8'hFF; pulse_len = 8'd3; holdoff = 8'd20;
    sig_in = ~sig_in; cyc(2); sig_in = ~sig_in; cyc(6);
    check("pre_reset_dropped", int'(dropped), 15);
    check("pre_reset_busy", int'(busy), 15);
    #1 reset = 1'b0;
    #1;
    check("reset_pulse", int'(pulse), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dropped", int'(dropped), 0);
    sig_in = '0; mode = 8'h55;
    cyc(2); #1 reset = 1'b1;
    cyc(2); sig_in = 4'hF;
    measure(0, 10, first, pw, bw);
    check("post_reset_width", pw, 3);
    check("post_reset_dropped", int'(dropped), 0);
    cyc(25);

    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
      sig_in        = sig_in ^ (CH'($urandom) & CH'($urandom));
      clear_dropped = CH'($urandom) & CH'($urandom) & CH'($urandom);
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 29) == 0) pulse_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) holdoff = 8'($urandom_range(0, 4));
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
